// File: rtl/retire_ctrl_pkg.sv
// Shared types for the retire stage: ROB head entry layout and controller state.
package retire_ctrl_pkg;

  localparam int PR_DEF   = 6;
  localparam int ROB_DEF  = 5;
  localparam int XLEN_DEF = 32;

  typedef struct packed {
    logic                completed;
    logic                precise_state_need;
    logic                halt;
    logic                is_store;
    logic [4:0]          arch_reg;
    logic [PR_DEF-1:0]   Tnew;
    logic [PR_DEF-1:0]   Told;
    logic [XLEN_DEF-1:0] target_pc;
  } ROB_ENTRY_PACKET;

  typedef enum logic [1:0] {RUN, RECOVER, HALTED} RETIRE_STATE;

endpackage

// File: rtl/retire_ctrl_slot_chain.sv
// In-order retire priority chain: oldest slot (W-1) first, stops at the first
// slot that cannot retire or at a retired halt/mispredict.
module retire_slot_chain
  import retire_ctrl_pkg::*;
#(
  parameter int RETIRE_WIDTH = 3,
  localparam int CNT_W = $clog2(RETIRE_WIDTH + 1),
  localparam int IDX_W = (RETIRE_WIDTH > 1) ? $clog2(RETIRE_WIDTH) : 1
) (
  input  ROB_ENTRY_PACKET [RETIRE_WIDTH-1:0] entry,
  input  logic [RETIRE_WIDTH-1:0]            sq_stall,
  input  logic                               run,
  output logic [RETIRE_WIDTH-1:0]            retire,
  output logic [CNT_W-1:0]                   write_cnt,
  output logic                               term_found,
  output logic                               term_halt,
  output logic [IDX_W-1:0]                   term_idx
);

  logic blocked;

  always_comb begin
    retire     = '0;
    write_cnt  = '0;
    term_found = 1'b0;
    term_halt  = 1'b0;
    term_idx   = '0;
    blocked    = !run;
    for (int i = RETIRE_WIDTH - 1; i >= 0; i--) begin
      if (!blocked && entry[i].completed && !(entry[i].is_store && sq_stall[i])) begin
        retire[i] = 1'b1;
        if (entry[i].arch_reg != 5'd0) write_cnt = write_cnt + 1'b1;
        if (entry[i].halt || entry[i].precise_state_need) begin
          term_found = 1'b1;
          term_halt  = entry[i].halt;  // halt beats mispredict on the same slot
          term_idx   = IDX_W'(i);
          blocked    = 1'b1;
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end

endmodule

// File: rtl/retire_ctrl.sv
// Retire controller: in-order retire enables, branch recovery state, halt latch
// and retired-instruction counter.
//   state   | meaning
//   RUN     | normal retire
//   RECOVER | retire blocked for RECOVER_CYCLES after a mispredict retires
//   HALTED  | halt retired; nothing retires until reset
module retire_ctrl
  import retire_ctrl_pkg::*;
#(
  parameter int RETIRE_WIDTH   = 3,
  parameter int RECOVER_CYCLES = 1,
  parameter int PR_W           = PR_DEF,
  parameter int ROB_W          = ROB_DEF,
  parameter int XLEN_W         = XLEN_DEF,
  localparam int IC_W          = $clog2(RETIRE_WIDTH + 1)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  ROB_ENTRY_PACKET [RETIRE_WIDTH-1:0]   rob_head_entry,
  input  logic [ROB_W-1:0]                     fl_distance,
  input  logic [ROB_W-1:0]                     FreelistHead,
  input  logic [31:0][PR_W-1:0]                archi_maptable,
  input  logic [RETIRE_WIDTH-1:0]              sq_stall,
  output logic [RETIRE_WIDTH-1:0]              Retire_EN,
  output logic [RETIRE_WIDTH-1:0]              SQRetireEN,
  output logic [RETIRE_WIDTH-1:0][4:0]         map_ar,
  output logic [RETIRE_WIDTH-1:0][PR_W-1:0]    map_ar_pr,
  output logic [RETIRE_WIDTH-1:0][PR_W-1:0]    Tolds_out,
  output logic [IC_W-1:0]                      inst_count,
  output logic                                 BPRecoverEN,
  output logic [XLEN_W-1:0]                    target_pc,
  output logic [31:0][PR_W-1:0]                recover_maptable,
  output logic [ROB_W-1:0]                     BPRecoverHead,
  output logic                                 halt,
  output logic [63:0]                          retired_total
);

  localparam int IDX_W = (RETIRE_WIDTH > 1) ? $clog2(RETIRE_WIDTH) : 1;
  localparam int CNT_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  RETIRE_STATE               state;
  logic [CNT_W-1:0]          rec_cnt;
  logic [RETIRE_WIDTH-1:0]   retire;
  logic [IC_W-1:0]           write_cnt;
  logic                      term_found, term_halt;
  logic [IDX_W-1:0]          term_idx;
  logic [31:0][PR_W-1:0]     merged_map;

  retire_slot_chain #(.RETIRE_WIDTH(RETIRE_WIDTH)) u_chain (
    .entry      (rob_head_entry),
    .sq_stall   (sq_stall),
    .run        ((state == RUN) && !reset),
    .retire     (retire),
    .write_cnt  (write_cnt),
    .term_found (term_found),
    .term_halt  (term_halt),
    .term_idx   (term_idx)
  );

  always_comb begin
    Retire_EN  = '0;
    SQRetireEN = '0;
    inst_count = '0;
    merged_map = archi_maptable;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      map_ar[i]    = rob_head_entry[i].arch_reg;
      map_ar_pr[i] = PR_W'(rob_head_entry[i].Tnew);
      Tolds_out[i] = PR_W'(rob_head_entry[i].Told);
      Retire_EN[i]  = retire[i] && (rob_head_entry[i].arch_reg != 5'd0);
      SQRetireEN[i] = retire[i] && rob_head_entry[i].is_store;
      inst_count    = inst_count + IC_W'(retire[i]);
    end
    // Oldest first so a younger write to the same arch reg wins.
    for (int i = RETIRE_WIDTH - 1; i >= 0; i--) begin
      if (Retire_EN[i]) merged_map[rob_head_entry[i].arch_reg] = PR_W'(rob_head_entry[i].Tnew);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= RUN;
      rec_cnt          <= '0;
      BPRecoverEN      <= 1'b0;
      halt             <= 1'b0;
      target_pc        <= '0;
      BPRecoverHead    <= '0;
      retired_total    <= '0;
      recover_maptable <= '0;
    end else begin
      BPRecoverEN   <= 1'b0;
      retired_total <= retired_total + 64'(inst_count);
      case (state)
        RUN: begin
          if (term_found && term_halt) begin
            halt  <= 1'b1;
            state <= HALTED;
          end else if (term_found) begin
            BPRecoverEN      <= 1'b1;
            target_pc        <= XLEN_W'(rob_head_entry[term_idx].target_pc);
            recover_maptable <= merged_map;
            BPRecoverHead    <= FreelistHead - (fl_distance - ROB_W'(write_cnt));
            rec_cnt          <= CNT_W'(RECOVER_CYCLES - 1);
            state            <= RECOVER;
          end
        end
        RECOVER: begin
          if (rec_cnt == '0) state <= RUN;
          else rec_cnt <= rec_cnt - 1'b1;
        end
        default: state <= HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_retire_ctrl.sv
// Directed bench for retire_ctrl: vector table for the retire chain plus
// hand-written recovery, halt and reset sequences.
module tb_retire_ctrl;
  import retire_ctrl_pkg::*;

  localparam int W = 3, RC = 2, PRW = 6, ROBW = 5, XW = 32;

  logic clock = 1'b0;
  logic reset;
  ROB_ENTRY_PACKET [W-1:0] rob_head_entry;
  logic [ROBW-1:0] fl_distance, FreelistHead;
  logic [31:0][PRW-1:0] archi_maptable;
  logic [W-1:0] sq_stall, Retire_EN, SQRetireEN;
  logic [W-1:0][4:0] map_ar;
  logic [W-1:0][PRW-1:0] map_ar_pr, Tolds_out;
  logic [1:0] inst_count;
  logic BPRecoverEN, halt;
  logic [XW-1:0] target_pc;
  logic [31:0][PRW-1:0] recover_maptable;
  logic [ROBW-1:0] BPRecoverHead;
  logic [63:0] retired_total;

  retire_ctrl #(.RETIRE_WIDTH(W), .RECOVER_CYCLES(RC), .PR_W(PRW), .ROB_W(ROBW), .XLEN_W(XW)) dut (
    .clock(clock), .reset(reset), .rob_head_entry(rob_head_entry), .fl_distance(fl_distance),
    .FreelistHead(FreelistHead), .archi_maptable(archi_maptable), .sq_stall(sq_stall),
    .Retire_EN(Retire_EN), .SQRetireEN(SQRetireEN), .map_ar(map_ar), .map_ar_pr(map_ar_pr),
    .Tolds_out(Tolds_out), .inst_count(inst_count), .BPRecoverEN(BPRecoverEN), .target_pc(target_pc),
    .recover_maptable(recover_maptable), .BPRecoverHead(BPRecoverHead), .halt(halt),
    .retired_total(retired_total)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;
  longint unsigned exp_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one rising edge; inputs are then driven and outputs checked at edge+1.
  task automatic tick(input int exp_ic);
    @(posedge clock);
    if (reset) exp_total = 0;
    else exp_total = exp_total + longint'(exp_ic);
    #1;
  endtask

  function automatic ROB_ENTRY_PACKET mk(input bit c, input bit psn, input bit h, input bit st,
                                         input int ar, input int tn, input int to, input int pc);
    ROB_ENTRY_PACKET e;
    e.completed = c; e.precise_state_need = psn; e.halt = h; e.is_store = st;
    e.arch_reg = 5'(ar); e.Tnew = PR_DEF'(tn); e.Told = PR_DEF'(to); e.target_pc = XLEN_DEF'(pc);
    return e;
  endfunction

  function automatic ROB_ENTRY_PACKET [W-1:0] plain3(input int a2, input int a1, input int a0);
    ROB_ENTRY_PACKET [W-1:0] r;
    r[2] = mk(1, 0, 0, 0, a2, 40, 50, 0);
    r[1] = mk(1, 0, 0, 0, a1, 41, 51, 0);
    r[0] = mk(1, 0, 0, 0, a0, 42, 52, 0);
    return r;
  endfunction

  typedef struct {
    ROB_ENTRY_PACKET [W-1:0] ent;
    logic [W-1:0] stall;
    logic [W-1:0] exp_ren;
    logic [W-1:0] exp_sq;
    int exp_ic;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // slot 2 oldest
    vecs[0].ent = plain3(5, 0, 7);                       vecs[0].stall = 3'b000;
    vecs[0].exp_ren = 3'b101; vecs[0].exp_sq = 3'b000;   vecs[0].exp_ic = 3;
    vecs[1].ent = plain3(5, 6, 7); vecs[1].ent[2].is_store = 1'b1; vecs[1].stall = 3'b100;
    vecs[1].exp_ren = 3'b000; vecs[1].exp_sq = 3'b000;   vecs[1].exp_ic = 0;
    vecs[2].ent = plain3(4, 2, 0); vecs[2].ent[2].is_store = 1'b1; vecs[2].stall = 3'b010;
    vecs[2].exp_ren = 3'b110; vecs[2].exp_sq = 3'b100;   vecs[2].exp_ic = 3;
    vecs[3].ent = plain3(4, 2, 3); vecs[3].ent[2].completed = 1'b0; vecs[3].stall = 3'b000;
    vecs[3].exp_ren = 3'b000; vecs[3].exp_sq = 3'b000;   vecs[3].exp_ic = 0;
    vecs[4].ent = plain3(1, 2, 3); vecs[4].ent[1].completed = 1'b0; vecs[4].stall = 3'b000;
    vecs[4].exp_ren = 3'b100; vecs[4].exp_sq = 3'b000;   vecs[4].exp_ic = 1;
    vecs[5].ent = plain3(3, 2, 1); vecs[5].ent[1].is_store = 1'b1; vecs[5].stall = 3'b010;
    vecs[5].exp_ren = 3'b100; vecs[5].exp_sq = 3'b000;   vecs[5].exp_ic = 1;
    vecs[6].ent = plain3(3, 2, 1); vecs[6].ent[0].is_store = 1'b1; vecs[6].stall = 3'b000;
    vecs[6].exp_ren = 3'b111; vecs[6].exp_sq = 3'b001;   vecs[6].exp_ic = 3;

    for (int r = 0; r < 32; r++) archi_maptable[r] = PRW'(r);
    reset = 1'b1; sq_stall = '0; fl_distance = '0; FreelistHead = '0;
    rob_head_entry = plain3(5, 6, 7);
    #1;
    chk("reset_gates_retire_en", 64'(Retire_EN), 64'd0);
    chk("reset_gates_inst_count", 64'(inst_count), 64'd0);
    tick(0); tick(0);
    reset = 1'b0;
    chk("reset_bp_en", 64'(BPRecoverEN), 64'd0);
    chk("reset_halt", 64'(halt), 64'd0);
    chk("reset_total", retired_total, 64'd0);
    chk("reset_head", 64'(BPRecoverHead), 64'd0);
    chk("pass_ar2", 64'(map_ar[2]), 64'd5);
    chk("pass_tnew1", 64'(map_ar_pr[1]), 64'd41);
    chk("pass_told0", 64'(Tolds_out[0]), 64'd52);

    for (int v = 0; v < 7; v++) begin
      rob_head_entry = vecs[v].ent; sq_stall = vecs[v].stall;
      #1;
      chk($sformatf("vec%0d_retire_en", v), 64'(Retire_EN), 64'(vecs[v].exp_ren));
      chk($sformatf("vec%0d_sq_en", v), 64'(SQRetireEN), 64'(vecs[v].exp_sq));
      chk($sformatf("vec%0d_inst_count", v), 64'(inst_count), 64'(vecs[v].exp_ic));
      tick(vecs[v].exp_ic);
      chk($sformatf("vec%0d_total", v), retired_total, exp_total);
    end
    sq_stall = '0;

    // Mispredict on slot 1, both slots 2 and 1 write r3 (younger wins in the map).
    rob_head_entry = plain3(3, 3, 7);
    rob_head_entry[2].Tnew = 6'd10;
    rob_head_entry[1] = mk(1, 1, 0, 0, 3, 11, 12, 32'h400);
    fl_distance = 5'd5; FreelistHead = 5'd2;
    #1;
    chk("bp_T_retire_en", 64'(Retire_EN), 64'b110);
    chk("bp_T_inst_count", 64'(inst_count), 64'd2);
    tick(2);
    rob_head_entry = plain3(4, 5, 6);
    fl_distance = 5'd9; FreelistHead = 5'd7;
    #1;
    chk("bp_T1_en", 64'(BPRecoverEN), 64'd1);
    chk("bp_T1_pc", 64'(target_pc), 64'h400);
    chk("bp_T1_head_wrap", 64'(BPRecoverHead), 64'd31);
    chk("bp_T1_map3", 64'(recover_maptable[3]), 64'd11);
    chk("bp_T1_map1", 64'(recover_maptable[1]), 64'd1);
    chk("bp_T1_map7", 64'(recover_maptable[7]), 64'd7);
    chk("bp_T1_blocked", 64'(inst_count), 64'd0);
    tick(0);
    chk("bp_T2_en_drop", 64'(BPRecoverEN), 64'd0);
    chk("bp_T2_blocked", 64'(inst_count), 64'd0);
    chk("bp_T2_head_held", 64'(BPRecoverHead), 64'd31);
    tick(0);
    chk("bp_T3_resume", 64'(inst_count), 64'd3);
    chk("bp_T3_retire_en", 64'(Retire_EN), 64'b111);
    tick(3);
    chk("bp_total", retired_total, exp_total);

    // Halt and mispredict on the same slot: halt wins.
    rob_head_entry = plain3(2, 5, 6);
    rob_head_entry[2].halt = 1'b1; rob_head_entry[2].precise_state_need = 1'b1;
    rob_head_entry[2].target_pc = 32'h999;
    #1;
    chk("halt_T_inst_count", 64'(inst_count), 64'd1);
    chk("halt_T_retire_en", 64'(Retire_EN), 64'b100);
    tick(1);
    rob_head_entry = plain3(4, 5, 6);
    #1;
    chk("halt_T1_halt", 64'(halt), 64'd1);
    chk("halt_T1_no_bp", 64'(BPRecoverEN), 64'd0);
    chk("halt_T1_pc_held", 64'(target_pc), 64'h400);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("halt_block_c%0d", c), 64'(inst_count), 64'd0);
      tick(0);
    end
    chk("halt_sticky", 64'(halt), 64'd1);
    chk("halt_total", retired_total, exp_total);
    reset = 1'b1;
    tick(0);
    reset = 1'b0;
    #1;
    chk("halt_reset_clear", 64'(halt), 64'd0);
    chk("halt_reset_total", retired_total, 64'd0);
    chk("halt_reset_retire", 64'(inst_count), 64'd3);
    tick(3);

    // Reset while in RECOVER.
    rob_head_entry = plain3(2, 5, 6);
    rob_head_entry[2].precise_state_need = 1'b1; rob_head_entry[2].target_pc = 32'h80;
    fl_distance = 5'd3; FreelistHead = 5'd10;
    #1;
    chk("rr_T_inst_count", 64'(inst_count), 64'd1);
    tick(1);
    chk("rr_T1_en", 64'(BPRecoverEN), 64'd1);
    chk("rr_T1_head", 64'(BPRecoverHead), 64'd8);
    rob_head_entry = plain3(4, 5, 6);
    reset = 1'b1;
    tick(0);
    reset = 1'b0;
    #1;
    chk("rr_bp_en", 64'(BPRecoverEN), 64'd0);
    chk("rr_pc", 64'(target_pc), 64'd0);
    chk("rr_head", 64'(BPRecoverHead), 64'd0);
    chk("rr_map3", 64'(recover_maptable[3]), 64'd0);
    chk("rr_retire_now", 64'(inst_count), 64'd3);
    tick(3);
    chk("rr_total", retired_total, exp_total);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/retire_ctrl.md
# retire_ctrl

Parametrised, stateful successor to the 3-wide retire stage. Takes the `RETIRE_WIDTH` oldest ROB entries each cycle and decides in-order which of them retire. It drives the architectural map table, free list and store-queue retire enables combinationally. It registers branch-recovery state, holds a retire-blocking recovery window, latches halt and keeps a retired-instruction counter. It sits between the ROB head and the arch map table, free list, store queue and fetch redirect.

## Interface
- `RETIRE_WIDTH`, 3: retire slots per cycle. Slot `RETIRE_WIDTH-1` is the oldest, slot 0 the youngest.
- `RECOVER_CYCLES`, 1: cycles retire stays blocked after a recovery is issued. Must be ≥1.
- `PR_W`, `` `PR ``: physical register tag width.
- `ROB_W`, `` `ROB ``: ROB/free-list pointer width.
- `XLEN_W`, `` `XLEN ``: PC width.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `rob_head_entry` in [RETIRE_WIDTH-1:0] `ROB_ENTRY_PACKET`: fields used are completed, precise_state_need, halt, is_store, arch_reg, Tnew, Told, target_pc.
- `fl_distance` in ROB_W: number of reg-writing instructions in the ROB.
- `FreelistHead` in ROB_W: current free-list head.
- `archi_maptable` in [31:0][PR_W-1:0]: arch map table before this cycle's writes.
- `sq_stall` in RETIRE_WIDTH: per-slot store-queue not-ready.
- `Retire_EN` out RETIRE_WIDTH: combinational; arch map / free-list write enable per slot.
- `SQRetireEN` out RETIRE_WIDTH: combinational; store retire per slot.
- `map_ar` out [RETIRE_WIDTH-1:0][4:0]: pass-through of arch_reg.
- `map_ar_pr` out [RETIRE_WIDTH-1:0][PR_W-1:0]: pass-through of Tnew.
- `Tolds_out` out [RETIRE_WIDTH-1:0][PR_W-1:0]: pass-through of Told.
- `inst_count` out $clog2(RETIRE_WIDTH+1): combinational count of slots retiring this cycle.
- `BPRecoverEN` out 1: registered one-cycle pulse.
- `target_pc` out XLEN_W: registered redirect PC.
- `recover_maptable` out [31:0][PR_W-1:0]: registered recovered map table.
- `BPRecoverHead` out ROB_W: registered recovered free-list head.
- `halt` out 1: registered, sticky until reset.
- `retired_total` out 64: registered running count of retired instructions.

## Operation
- Controller states: RUN, RECOVER, HALTED.
- A slot retires only when all of the following hold:
  - state is RUN;
  - every older slot retired this cycle;
  - no older slot terminated the group (a terminator is a retired slot with halt or precise_state_need set);
  - the slot's completed bit is 1;
  - the slot is not a store with `sq_stall[i]` set.
- A retiring slot drives `Retire_EN[i]` = (arch_reg != 0) and `SQRetireEN[i]` = is_store.
- If a slot has both halt and precise_state_need set, halt wins and no recovery is issued.
- Mispredict retire (precise_state_need) in cycle T, at the closing edge:
  - `recover_maptable` = `archi_maptable` with the group's writes applied oldest-to-youngest; arch_reg 0 is skipped.
  - `BPRecoverHead` = `FreelistHead` − (`fl_distance` − number of writing slots retired in T), computed modulo 2^ROB_W so wrap-around is intended.
  - `target_pc` = the branch slot's target_pc; `BPRecoverEN` = 1.
  - The recovery counter loads `RECOVER_CYCLES`−1 and state goes to RECOVER.
- RECOVER: no retires; `BPRecoverEN` drops after one cycle; the counter decrements; at 0 the state goes to RUN.
- Halt retire in cycle T: `halt` = 1 from T+1, state goes to HALTED, and no further retires until reset.
- `retired_total` adds `inst_count` every cycle. A carry out of bit 63 is dropped.
- Reset, including mid-RECOVER or while HALTED:
  - state = RUN, counter = 0;
  - `BPRecoverEN`, `halt`, `target_pc`, `BPRecoverHead`, `retired_total` and `recover_maptable` all = 0.
  - While `reset` is high, all combinational enables are 0.

## Timing
- Retire enables, pass-throughs and `inst_count` are valid in the same cycle as `rob_head_entry` (zero latency).
- Recovery outputs appear exactly 1 cycle after the mispredict retires.
- With a mispredict retiring in cycle T, retire is blocked for cycles T+1 … T+RECOVER_CYCLES. Earliest next retire is T+RECOVER_CYCLES+1.
- `halt` rises in the cycle after the halt instruction retires.
- Inputs are sampled only in the decision cycle; recovery ignores later changes to `fl_distance` or `FreelistHead`.

## Structure
- Shared package (`sys_defs.svh`): `ROB_ENTRY_PACKET` (existing) and a new `RETIRE_STATE` enum {RUN, RECOVER, HALTED}.
- Sub-module `retire_slot_chain`: purely combinational priority chain producing the per-slot retire vector, the terminator index and the write count.
- `retire_ctrl` holds the FSM, recovery registers, map-table merge and counters.

## Test plan
- W=3, all slots completed, no branches, arch_regs 5/0/7 → `Retire_EN`=101, `inst_count`=3, `retired_total` +3 at the edge.
- Slot 2 completed store with `sq_stall[2]`=1, slots 1 and 0 completed → nothing retires, `inst_count`=0.
- Slot 1 mispredict (target 0x400), slot 2 writes r3, `fl_distance`=5, `FreelistHead`=2, ROB_W=5 (32 entries) → slots 2 and 1 retire in T.
  - T+1: `BPRecoverEN`=1, `target_pc`=0x400, `BPRecoverHead`=2−(5−2)=31 (wraps).
  - With RECOVER_CYCLES=2: no retire in T+1 or T+2; retire resumes at T+3.
- Slot 2 halt with slots 1 and 0 completed → only slot 2 retires; `halt`=1 from T+1; retire stays blocked for 10 more cycles; `reset` clears `halt`.
- `reset` asserted during RECOVER → next cycle state is RUN, `BPRecoverEN`=0, and completed entries retire immediately.
